// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM slot arbiter.
package vram_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_SP   = 2'd2,
    OWN_CPU  = 2'd3
  } owner_t;

  localparam logic [1:0] PH_NAME = 2'd0;
  localparam logic [1:0] PH_SP   = 2'd1;
  localparam logic [1:0] PH_PAT  = 2'd2;
  localparam logic [1:0] PH_CPU  = 2'd3;

  // BUSY is split so the FSM knows exactly when the access has drained.
  typedef enum logic [1:0] {
    CPU_IDLE  = 2'd0,
    CPU_BUSY1 = 2'd1,
    CPU_BUSY2 = 2'd2
  } cpu_state_t;

  function automatic logic is_pattern_slot(input logic [1:0] phase);
    return (phase == PH_PAT);
  endfunction

endpackage

// File: rtl/vram_slot_decode.sv
// Combinational slot owner selection from the video timing position,
// the enable and the CPU requester state.
module vram_slot_decode
  import vram_pkg::*;
(
  input  logic       cs,
  input  logic       h_active,
  input  logic       v_active,
  input  logic       sp_v_active,
  input  logic [1:0] h_phase,
  input  logic       cpu_req,
  input  logic       cpu_idle,
  output logic [1:0] owner
);

  owner_t w_cpu_slot;
  owner_t w_owner;

  // Owner for the current cycle.
  always_comb begin
    w_cpu_slot = (cpu_idle && cpu_req) ? OWN_CPU : OWN_NONE;
    w_owner    = OWN_NONE;
    if (!cs) begin
      w_owner = OWN_NONE;
    end else if (h_active && v_active) begin
      case (h_phase)
        PH_NAME, PH_PAT: w_owner = OWN_DISP;
        PH_SP:           w_owner = sp_v_active ? OWN_SP : w_cpu_slot;
        PH_CPU:          w_owner = w_cpu_slot;
        default:         w_owner = OWN_NONE;
      endcase
    end else begin
      w_owner = w_cpu_slot;
    end
  end

  assign owner = w_owner;

endmodule

// File: rtl/vram_slot_arb.sv
// VRAM time-slot arbiter: fixed display/sprite slots, CPU takes the rest.
// A two-stage owner pipeline routes the RAM read data back to its requester.
module vram_slot_arb
  import vram_pkg::*;
#(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          h_active,
  input  logic          v_active,
  input  logic          sp_v_active,
  input  logic [1:0]    h_phase,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  output logic          disp_tag,
  input  logic [AW-1:0] sp_addr,
  output logic [DW-1:0] sp_data,
  output logic          sp_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0]    w_owner_raw;
  owner_t        w_owner;
  logic          w_cpu_idle;
  cpu_state_t    r_cpu_state;
  cpu_state_t    w_cpu_next;

  logic [AW-1:0] w_addr_nxt;
  logic          w_we_nxt;
  logic [DW-1:0] w_wdata_nxt;
  logic          w_tag_nxt;

  logic [AW-1:0] r_mem_addr;
  logic          r_mem_we;
  logic [DW-1:0] r_mem_wdata;
  owner_t        r_own1;
  logic          r_tag1;

  logic          r_disp_valid;
  logic          r_disp_tag;
  logic          r_sp_valid;
  logic          r_cpu_ack;
  logic [DW-1:0] r_disp_hold;
  logic [DW-1:0] r_sp_hold;
  logic [DW-1:0] r_cpu_hold;

  assign w_cpu_idle = (r_cpu_state == CPU_IDLE);

  vram_slot_decode u_decode (
    .cs          (cs),
    .h_active    (h_active),
    .v_active    (v_active),
    .sp_v_active (sp_v_active),
    .h_phase     (h_phase),
    .cpu_req     (cpu_req),
    .cpu_idle    (w_cpu_idle),
    .owner       (w_owner_raw)
  );

  assign w_owner = owner_t'(w_owner_raw);

  // CPU FSM next state: a grant occupies the two following cycles.
  always_comb begin
    w_cpu_next = r_cpu_state;
    case (r_cpu_state)
      CPU_IDLE:  w_cpu_next = (w_owner == OWN_CPU) ? CPU_BUSY1 : CPU_IDLE;
      CPU_BUSY1: w_cpu_next = CPU_BUSY2;
      CPU_BUSY2: w_cpu_next = CPU_IDLE;
      default:   w_cpu_next = CPU_IDLE;
    endcase
  end

  // CPU FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_state <= CPU_IDLE;
    end else begin
      r_cpu_state <= w_cpu_next;
    end
  end

  // Access mux; idle cycles hold address and write data to avoid bus toggling.
  always_comb begin
    w_addr_nxt  = r_mem_addr;
    w_we_nxt    = 1'b0;
    w_wdata_nxt = r_mem_wdata;
    w_tag_nxt   = 1'b0;
    case (w_owner)
      OWN_DISP: begin
        w_addr_nxt = disp_addr;
        w_tag_nxt  = is_pattern_slot(h_phase);
      end
      OWN_SP: begin
        w_addr_nxt = sp_addr;
      end
      OWN_CPU: begin
        w_addr_nxt  = cpu_addr;
        w_we_nxt    = cpu_we;
        w_wdata_nxt = cpu_wdata;
      end
      OWN_NONE: begin
        w_addr_nxt = r_mem_addr;
      end
      default: begin
        w_addr_nxt = r_mem_addr;
      end
    endcase
  end

  // Stage 1: RAM command plus owner/tag of the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_own1      <= OWN_NONE;
      r_tag1      <= 1'b0;
    end else begin
      r_mem_addr  <= w_addr_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_own1      <= w_owner;
      r_tag1      <= w_tag_nxt;
    end
  end

  // Stage 2: strobes line up with the cycle the RAM returns data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp_valid <= 1'b0;
      r_disp_tag   <= 1'b0;
      r_sp_valid   <= 1'b0;
      r_cpu_ack    <= 1'b0;
    end else begin
      r_disp_valid <= (r_own1 == OWN_DISP);
      r_sp_valid   <= (r_own1 == OWN_SP);
      r_cpu_ack    <= (r_own1 == OWN_CPU);
      r_disp_tag   <= (r_own1 == OWN_DISP) ? r_tag1 : r_disp_tag;
    end
  end

  // Keep the last returned word on each data output between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp_hold <= '0;
      r_sp_hold   <= '0;
      r_cpu_hold  <= '0;
    end else begin
      r_disp_hold <= r_disp_valid ? mem_rdata : r_disp_hold;
      r_sp_hold   <= r_sp_valid   ? mem_rdata : r_sp_hold;
      r_cpu_hold  <= r_cpu_ack    ? mem_rdata : r_cpu_hold;
    end
  end

  assign disp_valid = r_disp_valid;
  assign disp_tag   = r_disp_tag;
  assign disp_data  = r_disp_valid ? mem_rdata : r_disp_hold;
  assign sp_valid   = r_sp_valid;
  assign sp_data    = r_sp_valid ? mem_rdata : r_sp_hold;
  assign cpu_ack    = r_cpu_ack;
  assign cpu_rdata  = r_cpu_ack ? mem_rdata : r_cpu_hold;
  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_vram_slot_arb.sv
// Scoreboard bench for vram_slot_arb with a behavioural slot/RAM model.
module tb_vram_slot_arb;
  import vram_pkg::*;

  localparam int AW = 14;
  localparam int DW = 8;

  logic          clk;
  logic          reset, cs, h_active, v_active, sp_v_active;
  logic [1:0]    h_phase;
  logic [AW-1:0] disp_addr, sp_addr, cpu_addr, mem_addr;
  logic [DW-1:0] disp_data, sp_data, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic          disp_valid, disp_tag, sp_valid, cpu_req, cpu_we, cpu_ack, mem_we;

  vram_slot_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .cs(cs), .h_active(h_active), .v_active(v_active),
    .sp_v_active(sp_v_active), .h_phase(h_phase),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid), .disp_tag(disp_tag),
    .sp_addr(sp_addr), .sp_data(sp_data), .sp_valid(sp_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] ram_init(input logic [AW-1:0] a);
    return DW'(a * 7) ^ DW'(a >> 5);
  endfunction

  // Synchronous single-port RAM, 1-cycle read latency.
  logic [DW-1:0] ram    [0:(1<<AW)-1];
  bit            ram_wr [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : ram_init(mem_addr);
  end

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    int            due;
    int            kind;   // 1 display, 2 sprite, 3 cpu
    logic          tag;
    logic          chk_data;
    logic [DW-1:0] data;
  } rsp_exp_t;

  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];
  int       rst_q[$];
  int       total = 0;
  int       bad = 0;

  logic [DW-1:0] mdl_mem [int];
  int            m_grant = -100;
  logic [AW-1:0] m_last_addr = '0;
  logic [DW-1:0] m_last_wdata = '0;
  logic [1:0]    ph_cnt = 2'd0;
  bit            rq_on = 1'b0;
  int            rq_grant = -1;
  int            rq_start = 0;
  bit            wchk_en = 1'b0;

  function automatic logic [DW-1:0] mdl_rd(input logic [AW-1:0] a);
    if (mdl_mem.exists(int'(a))) return mdl_mem[int'(a)];
    return ram_init(a);
  endfunction

  // Slot rules: active lines are quads of name/sprite/pattern/free slots.
  function automatic int ref_owner(input bit cs_i, input bit ha, input bit va, input bit spv,
                                   input logic [1:0] ph, input bit req, input bit busy);
    bit cpu_ok;
    cpu_ok = req && !busy;
    if (!cs_i) return 0;
    if (!(ha && va)) return cpu_ok ? 3 : 0;
    if (ph[0] == 1'b0) return 1;
    if (ph == 2'd1 && spv) return 2;
    return cpu_ok ? 3 : 0;
  endfunction

  task automatic step(input bit rst);
    int k, own;
    mem_exp_t m;
    rsp_exp_t r;
    k = cyc;
    reset = rst;
    h_phase = ph_cnt;
    if (rst) begin
      m.cyc = k + 1; m.addr = '0; m.we = 1'b0; m.wdata = '0;
      mem_q.push_back(m);
      for (int i = rsp_q.size() - 1; i >= 0; i--)
        if (rsp_q[i].due >= k + 1) rsp_q.delete(i);
      rst_q.push_back(k + 1);
      m_grant = -100; m_last_addr = '0; m_last_wdata = '0;
      rq_on = 1'b0; rq_grant = -1;
    end else begin
      own = ref_owner(cs, h_active, v_active, sp_v_active, ph_cnt, cpu_req, (k - m_grant) <= 2);
      m.cyc = k + 1; m.we = 1'b0; m.addr = m_last_addr; m.wdata = m_last_wdata;
      r.due = k + 2; r.kind = own; r.tag = 1'b0; r.chk_data = 1'b1; r.data = '0;
      case (own)
        1: begin m.addr = disp_addr; r.tag = (ph_cnt == 2'd2); r.data = mdl_rd(disp_addr); end
        2: begin m.addr = sp_addr; r.data = mdl_rd(sp_addr); end
        3: begin
          m.addr = cpu_addr; m.we = cpu_we; m.wdata = cpu_wdata;
          if (cpu_we) begin
            r.chk_data = 1'b0;
            mdl_mem[int'(cpu_addr)] = cpu_wdata;
          end else begin
            r.data = mdl_rd(cpu_addr);
          end
          m_grant = k; rq_grant = k; m_last_wdata = cpu_wdata;
        end
        default: ;
      endcase
      m_last_addr = m.addr;
      mem_q.push_back(m);
      if (own != 0) rsp_q.push_back(r);
    end
    ph_cnt = ph_cnt + 2'd1;
    @(posedge clk);
    #1;
  endtask

  // Requester: holds a request until three cycles after its grant.
  task automatic drive_cpu(input int pct);
    if (rq_on && rq_grant >= 0 && cyc >= rq_grant + 3) begin
      rq_on = 1'b0; rq_grant = -1;
    end
    if (!rq_on && int'($urandom_range(99)) < pct) begin
      rq_on = 1'b1; rq_grant = -1; rq_start = cyc;
      cpu_we = 1'($urandom_range(1));
      cpu_addr = AW'($urandom_range(63));
      cpu_wdata = DW'($urandom);
    end
    cpu_req = rq_on;
  endtask

  task automatic run_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rq_on = 1'b1; rq_grant = -1; rq_start = cyc;
    cpu_we = we; cpu_addr = a; cpu_wdata = d;
    for (int i = 0; i < 24; i++) begin
      drive_cpu(0);
      if (!rq_on) break;
      step(1'b0);
    end
  endtask

  // Monitor: compares RAM command and returned strobes against the scoreboard.
  always @(negedge clk) begin : mon
    mem_exp_t e;
    rsp_exp_t r;
    int c;
    logic [2:0] gv, ev;
    logic [DW-1:0] gd;
    c = cyc;
    if (c > 0) begin
      if (mem_q.size() > 0 && mem_q[0].cyc == c) begin
        e = mem_q.pop_front();
        total++;
        if (mem_addr !== e.addr || mem_we !== e.we || mem_wdata !== e.wdata) begin
          bad++;
          $display("FAIL mem_cmd cyc=%0d got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                   c, mem_addr, mem_we, mem_wdata, e.addr, e.we, e.wdata);
        end
      end
      gv = {disp_valid, sp_valid, cpu_ack};
      total++;
      if (rsp_q.size() > 0 && rsp_q[0].due == c) begin
        r = rsp_q.pop_front();
        ev = {r.kind == 1, r.kind == 2, r.kind == 3};
        gd = (r.kind == 1) ? disp_data : (r.kind == 2) ? sp_data : cpu_rdata;
        if (gv !== ev || (r.kind == 1 && disp_tag !== r.tag) || (r.chk_data && gd !== r.data)) begin
          bad++;
          $display("FAIL response cyc=%0d got strobes=%b tag=%b data=%h want strobes=%b tag=%b data=%h",
                   c, gv, disp_tag, gd, ev, r.tag, r.data);
        end
      end else if (gv !== 3'b000) begin
        bad++;
        $display("FAIL spurious_strobe cyc=%0d got strobes=%b want 000", c, gv);
      end
      if (rst_q.size() > 0 && rst_q[0] == c) begin
        void'(rst_q.pop_front());
        total++;
        if (disp_data !== '0 || sp_data !== '0 || cpu_rdata !== '0 || disp_tag !== 1'b0) begin
          bad++;
          $display("FAIL reset_outputs cyc=%0d got disp=%h sp=%h cpu=%h tag=%b want all 0",
                   c, disp_data, sp_data, cpu_rdata, disp_tag);
        end
      end
      if (wchk_en && cpu_ack === 1'b1) begin
        total++;
        if (c - rq_start > 6) begin
          bad++;
          $display("FAIL cpu_wait cyc=%0d got req_to_ack=%0d want <=6", c, c - rq_start);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; cs = 1'b0; h_active = 1'b0; v_active = 1'b0; sp_v_active = 1'b0;
    h_phase = 2'd0; disp_addr = '0; sp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    repeat (3) step(1'b1);

    // Outside active: write then read back.
    cs = 1'b1;
    run_req(1'b1, 14'h0123, 8'h5A);
    run_req(1'b0, 14'h0123, 8'h00);
    run_req(1'b1, 14'h0010, 8'hA5);
    run_req(1'b0, 14'h0010, 8'h00);
    cpu_req = 1'b0;
    repeat (3) step(1'b0);

    // Active line, no sprites, CPU request held.
    h_active = 1'b1; v_active = 1'b1; sp_v_active = 1'b0; ph_cnt = 2'd0;
    for (int i = 0; i < 48; i++) begin
      disp_addr = AW'($urandom_range(63));
      drive_cpu(100);
      step(1'b0);
    end

    // Active line with sprite slots; CPU wait bounded.
    sp_v_active = 1'b1; sp_addr = 14'h2000; wchk_en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      disp_addr = AW'($urandom_range(63));
      drive_cpu(100);
      step(1'b0);
    end
    wchk_en = 1'b0;

    // cs drops right after a CPU grant: the ack must still arrive.
    for (int i = 0; i < 20; i++) begin
      drive_cpu(100);
      step(1'b0);
      if (rq_grant == cyc - 1) break;
    end
    cs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_cpu(100);
      step(1'b0);
    end

    // Reset in the cycle after a CPU read grant.
    h_active = 1'b0; cs = 1'b1;
    for (int i = 0; i < 10 && rq_on; i++) begin
      drive_cpu(0);
      step(1'b0);
    end
    rq_on = 1'b1; rq_grant = -1; cpu_we = 1'b0; cpu_addr = 14'h0010; cpu_req = 1'b1;
    for (int i = 0; i < 6 && rq_grant < 0; i++) step(1'b0);
    step(1'b1);
    cpu_req = 1'b0;
    step(1'b0);
    run_req(1'b0, 14'h0010, 8'h00);

    // Randomised timing, enable, requests and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 3) h_active = ~h_active;
      if ($urandom_range(99) < 1) v_active = ~v_active;
      if ($urandom_range(99) < 2) sp_v_active = ~sp_v_active;
      if ($urandom_range(99) < 1) ph_cnt = 2'($urandom);
      cs = ($urandom_range(99) < 95);
      disp_addr = AW'($urandom_range(63));
      sp_addr = ($urandom_range(1) == 1) ? AW'($urandom_range(63)) : 14'h2000;
      drive_cpu(40);
      step($urandom_range(199) == 0);
    end

    cs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_cpu(0);
      step(1'b0);
    end

    total++;
    if (rsp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want 0", rsp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_slot_arb.md
# vram_slot_arb

Time-slot arbiter for the single-port video RAM, shared between the background display fetcher, the sprite fetcher and the CPU. It sits beside the video timing generator and takes `h_active`, `v_active`, `sp_v_active` and the low bits of `h_count` from it. During active lines it grants fixed slots to display and sprite fetches; all remaining bandwidth goes to the CPU through a req/ack handshake. It drives a synchronous RAM with 1-cycle read latency.

## Interface
- `AW`, 14: VRAM address width.
- `DW`, 8: VRAM data width.

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `cs`  in  1  enable; 0 = no new grants, in-flight accesses complete
- `h_active`  in  1  from timing generator
- `v_active`  in  1  from timing generator
- `sp_v_active`  in  1  sprite line window, from timing generator
- `h_phase`  in  2  `h_count[1:0]` from timing generator
- `disp_addr`  in  AW  display fetch address, sampled in slot cycle
- `disp_data`  out  DW  display read data
- `disp_valid`  out  1  `disp_data` valid, 1-cycle pulse
- `disp_tag`  out  1  slot of returned data: 0 = phase 0 (name), 1 = phase 2 (pattern)
- `sp_addr`  in  AW  sprite fetch address
- `sp_data`  out  DW  sprite read data
- `sp_valid`  out  1  `sp_data` valid pulse
- `cpu_req`  in  1  CPU request level
- `cpu_we`  in  1  1 = write
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_ack`  out  1  completion pulse
- `cpu_rdata`  out  DW  read data, valid with `cpu_ack`
- `mem_addr`  out  AW  registered RAM address
- `mem_we`  out  1  registered RAM write strobe
- `mem_wdata`  out  DW  registered RAM write data
- `mem_rdata`  in  DW  RAM read data, valid 1 cycle after `mem_addr`

## Operation
- Owner decision each cycle (cycle N, combinational):
  - `cs`=0: NONE.
  - `h_active & v_active`:
    - phase 0 or 2: DISP.
    - phase 1: SP if `sp_v_active`, else CPU.
    - phase 3: CPU.
  - Otherwise every cycle is CPU.
  - A CPU slot goes to NONE if the CPU FSM is not IDLE or `cpu_req`=0.
- The winning address, we and wdata are registered onto `mem_*` (cycle N+1).
  - `mem_we`=1 only for CPU writes.
  - NONE drives `mem_we`=0 and holds `mem_addr`.
- Owner and tag travel in a 2-stage pipeline alongside the access. In cycle N+2, `mem_rdata` is registered to the matching data output and its valid/ack pulses.
- CPU FSM:
  - IDLE: on a CPU grant, go to BUSY.
  - BUSY covers cycles N+1 and N+2.
  - `cpu_ack` pulses in N+2 for both reads and writes.
  - Return to IDLE at N+3.
  - The requester holds `cpu_req`, `cpu_addr`, `cpu_we` and `cpu_wdata` stable from assertion through the ack cycle. It may present a new request from N+3.
- Maximum CPU back-to-back rate is one access per 3 cycles.
- Worst-case wait during active display is 4 cycles.

## Timing
- Reset values: all `*_valid`, `cpu_ack` and `mem_we` = 0; `mem_addr`, `mem_wdata` and all data outputs = 0; CPU FSM = IDLE; pipeline owners = NONE.
- Reset mid-operation flushes the pipeline: no valid or ack is produced for accesses in flight.
- Latency is 2 cycles from the slot cycle to valid/ack for all requesters.
- Display and sprite have no handshake. Their slots are fixed, and data is returned even if the fetcher ignores it.
- `h_active` falling mid-quad: slot ownership switches in the same cycle and in-flight DISP/SP accesses still complete.
- `cs` deasserting while the CPU FSM is BUSY: the ack is still delivered.
- `cpu_req` dropped while BUSY is a protocol violation. The ack is still issued.

## Structure
- Shared package `vram_pkg`:
  - owner enum (OWN_NONE, OWN_DISP, OWN_SP, OWN_CPU)
  - phase constants (PH_NAME=0, PH_SP=1, PH_PAT=2, PH_CPU=3)
  - CPU FSM state enum
- One sub-module, `vram_slot_decode`: combinational owner select from timing inputs, `cs`, `cpu_req` and FSM state.
- Pipeline, mux and FSM stay in the top module.

## Test plan
- Outside active, CPU read of 0x0123 holding 0x5A: `cpu_req` at cycle 0 → `mem_addr`=0x0123 at cycle 1, `cpu_ack`=1 and `cpu_rdata`=0x5A at cycle 2, next grant no earlier than cycle 3.
- Active line, `sp_v_active`=0, phases 0..3 repeating, `cpu_req` held: `mem_addr` sequence DISP, CPU, DISP, idle; `disp_tag` returns 0, 1; exactly one `cpu_ack` per completed access.
- Active line, `sp_v_active`=1, `sp_addr`=0x2000: phase 1 grants SP, `sp_valid` 2 cycles later; CPU is granted only at phase 3, with a measured wait ≤4 cycles.
- CPU write 0xA5 to 0x0010, then a read of 0x0010: `mem_we` is 1 for exactly one cycle, and the read returns 0xA5.
- `reset` asserted in cycle N+1 of a CPU read: no `cpu_ack`, all outputs at reset values the next cycle, FSM IDLE.
- `cs`=0 during an active line: `mem_we`=0 and no valid pulses after the pipeline drains; an in-flight `cpu_ack` still arrives.
